// File: rtl/wt_dcache_vld_ctrl_pkg.sv
// Shared types and default geometry for the dcache tag/valid write-port controller.
package wt_dcache_vld_ctrl_pkg;

    localparam int unsigned DCACHE_NUM_WORDS    = 256;
    localparam int unsigned DCACHE_SET_ASSOC    = 8;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;
    localparam int unsigned DCACHE_LINE_WIDTH   = 128;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        FLUSH,
        DONE
    } vld_ctrl_state_e;

endpackage

// File: rtl/wt_dcache_vld_ctrl_if.sv
// Request/ack handshakes plus the full-cacheline write port driven by the valid controller.
interface wt_dcache_vld_ctrl_if #(
    parameter int unsigned NumWays   = wt_dcache_vld_ctrl_pkg::DCACHE_SET_ASSOC,
    parameter int unsigned IdxWidth  = wt_dcache_vld_ctrl_pkg::DCACHE_CL_IDX_WIDTH,
    parameter int unsigned TagWidth  = wt_dcache_vld_ctrl_pkg::DCACHE_TAG_WIDTH,
    parameter int unsigned LineWidth = wt_dcache_vld_ctrl_pkg::DCACHE_LINE_WIDTH,
    parameter int unsigned OffWidth  = wt_dcache_vld_ctrl_pkg::DCACHE_OFFSET_WIDTH
);
    logic                   busy_o;
    logic                   flush_i;
    logic                   flush_ack_o;
    logic                   inval_vld_i;
    logic [IdxWidth-1:0]    inval_idx_i;
    logic [NumWays-1:0]     inval_way_i;
    logic                   inval_ack_o;
    logic                   fill_vld_i;
    logic                   fill_ack_o;
    logic                   fill_nc_i;
    logic [NumWays-1:0]     fill_way_i;
    logic [TagWidth-1:0]    fill_tag_i;
    logic [IdxWidth-1:0]    fill_idx_i;
    logic [OffWidth-1:0]    fill_off_i;
    logic [LineWidth-1:0]   fill_data_i;
    logic [LineWidth/8-1:0] fill_be_i;
    logic                   wr_cl_vld_o;
    logic                   wr_cl_nc_o;
    logic [NumWays-1:0]     wr_cl_we_o;
    logic [TagWidth-1:0]    wr_cl_tag_o;
    logic [IdxWidth-1:0]    wr_cl_idx_o;
    logic [OffWidth-1:0]    wr_cl_off_o;
    logic [LineWidth-1:0]   wr_cl_data_o;
    logic [LineWidth/8-1:0] wr_cl_data_be_o;
    logic [NumWays-1:0]     wr_vld_bits_o;

    // Requester/memory side
    modport master (
        output flush_i, inval_vld_i, inval_idx_i, inval_way_i,
               fill_vld_i, fill_nc_i, fill_way_i, fill_tag_i, fill_idx_i,
               fill_off_i, fill_data_i, fill_be_i,
        input  busy_o, flush_ack_o, inval_ack_o, fill_ack_o,
               wr_cl_vld_o, wr_cl_nc_o, wr_cl_we_o, wr_cl_tag_o, wr_cl_idx_o,
               wr_cl_off_o, wr_cl_data_o, wr_cl_data_be_o, wr_vld_bits_o
    );

    // Controller side
    modport slave (
        input  flush_i, inval_vld_i, inval_idx_i, inval_way_i,
               fill_vld_i, fill_nc_i, fill_way_i, fill_tag_i, fill_idx_i,
               fill_off_i, fill_data_i, fill_be_i,
        output busy_o, flush_ack_o, inval_ack_o, fill_ack_o,
               wr_cl_vld_o, wr_cl_nc_o, wr_cl_we_o, wr_cl_tag_o, wr_cl_idx_o,
               wr_cl_off_o, wr_cl_data_o, wr_cl_data_be_o, wr_vld_bits_o
    );
endinterface

// File: rtl/wt_dcache_vld_ctrl.sv
// Sole driver of the dcache full-cacheline write port: post-reset clear sweep,
// flush sweep, and fixed-priority refill/invalidate grants (one write per cycle).
module wt_dcache_vld_ctrl
    import wt_dcache_vld_ctrl_pkg::*;
#(
    parameter int unsigned NumIdx    = DCACHE_NUM_WORDS,
    parameter int unsigned NumWays   = DCACHE_SET_ASSOC,
    parameter int unsigned IdxWidth  = $clog2(NumIdx),
    parameter int unsigned TagWidth  = DCACHE_TAG_WIDTH,
    parameter int unsigned LineWidth = DCACHE_LINE_WIDTH,
    parameter int unsigned OffWidth  = DCACHE_OFFSET_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    wt_dcache_vld_ctrl_if.slave    bus
);

    vld_ctrl_state_e     state_q, state_d;
    logic [IdxWidth-1:0] cnt_q, cnt_d;

    // Outputs are purely combinational: the memory samples the port directly.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        bus.busy_o          = 1'b0;
        bus.flush_ack_o     = 1'b0;
        bus.inval_ack_o     = 1'b0;
        bus.fill_ack_o      = 1'b0;
        bus.wr_cl_vld_o     = 1'b0;
        bus.wr_cl_nc_o      = 1'b0;
        bus.wr_cl_we_o      = {NumWays{1'b0}};
        bus.wr_cl_tag_o     = {TagWidth{1'b0}};
        bus.wr_cl_idx_o     = {IdxWidth{1'b0}};
        bus.wr_cl_off_o     = {OffWidth{1'b0}};
        bus.wr_cl_data_o    = {LineWidth{1'b0}};
        bus.wr_cl_data_be_o = {(LineWidth/8){1'b0}};
        bus.wr_vld_bits_o   = {NumWays{1'b0}};

        unique case (state_q)
            INIT, FLUSH: begin
                bus.busy_o      = 1'b1;
                bus.wr_cl_vld_o = 1'b1;
                bus.wr_cl_we_o  = {NumWays{1'b1}};
                bus.wr_cl_idx_o = cnt_q;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == IdxWidth'(NumIdx - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == INIT) ? IDLE : DONE;
                end
            end
            IDLE: begin
                if (bus.fill_vld_i) begin
                    bus.fill_ack_o      = 1'b1;
                    bus.wr_cl_vld_o     = 1'b1;
                    bus.wr_cl_nc_o      = bus.fill_nc_i;
                    bus.wr_cl_we_o      = bus.fill_way_i;
                    bus.wr_cl_tag_o     = bus.fill_tag_i;
                    bus.wr_cl_idx_o     = bus.fill_idx_i;
                    bus.wr_cl_off_o     = bus.fill_off_i;
                    bus.wr_cl_data_o    = bus.fill_data_i;
                    bus.wr_cl_data_be_o = bus.fill_be_i;
                    bus.wr_vld_bits_o   = bus.fill_way_i;
                end else if (bus.inval_vld_i) begin
                    bus.inval_ack_o = 1'b1;
                    bus.wr_cl_vld_o = 1'b1;
                    bus.wr_cl_we_o  = bus.inval_way_i;
                    bus.wr_cl_idx_o = bus.inval_idx_i;
                end else if (bus.flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                bus.flush_ack_o = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_vld_ctrl.sv
// Directed bench for wt_dcache_vld_ctrl with a cycle-level reference model checked every cycle.
module tb_wt_dcache_vld_ctrl;

    localparam int unsigned NumIdx    = 256;
    localparam int unsigned NumWays   = 8;
    localparam int unsigned IdxWidth  = 8;
    localparam int unsigned TagWidth  = 44;
    localparam int unsigned LineWidth = 128;
    localparam int unsigned OffWidth  = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    wt_dcache_vld_ctrl_if #(
        .NumWays  (NumWays),
        .IdxWidth (IdxWidth),
        .TagWidth (TagWidth),
        .LineWidth(LineWidth),
        .OffWidth (OffWidth)
    ) bus ();

    wt_dcache_vld_ctrl #(
        .NumIdx   (NumIdx),
        .NumWays  (NumWays),
        .IdxWidth (IdxWidth),
        .TagWidth (TagWidth),
        .LineWidth(LineWidth),
        .OffWidth (OffWidth)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the current sweep (-1 when none), sweep kind, ack owed.
    int m_pos      = 0;
    bit m_is_flush = 1'b0;
    bit m_ack_due  = 1'b0;
    bit model_on   = 1'b1;

    logic                   e_busy, e_fack, e_iack, e_ack, e_vld, e_nc;
    logic [NumWays-1:0]     e_we, e_bits;
    logic [TagWidth-1:0]    e_tag;
    logic [IdxWidth-1:0]    e_idx;
    logic [OffWidth-1:0]    e_off;
    logic [LineWidth-1:0]   e_data;
    logic [LineWidth/8-1:0] e_be;

    always @(negedge clk_i) begin
        if (model_on) begin
            if (!rst_ni) begin
                m_pos      = 0;
                m_is_flush = 1'b0;
                m_ack_due  = 1'b0;
            end
            e_busy = 0; e_fack = 0; e_iack = 0; e_ack = 0; e_vld = 0; e_nc = 0;
            e_we = '0; e_bits = '0; e_tag = '0; e_idx = '0; e_off = '0; e_data = '0; e_be = '0;
            if (m_pos >= 0) begin
                e_busy = 1; e_vld = 1; e_we = '1; e_idx = IdxWidth'(m_pos);
            end else if (m_ack_due) begin
                e_fack = 1;
            end else if (bus.fill_vld_i) begin
                e_ack = 1; e_vld = 1; e_nc = bus.fill_nc_i; e_we = bus.fill_way_i;
                e_bits = bus.fill_way_i; e_tag = bus.fill_tag_i; e_idx = bus.fill_idx_i;
                e_off = bus.fill_off_i; e_data = bus.fill_data_i; e_be = bus.fill_be_i;
            end else if (bus.inval_vld_i) begin
                e_iack = 1; e_vld = 1; e_we = bus.inval_way_i; e_idx = bus.inval_idx_i;
            end
            check("model.busy",      128'(bus.busy_o),          128'(e_busy));
            check("model.flush_ack", 128'(bus.flush_ack_o),     128'(e_fack));
            check("model.inval_ack", 128'(bus.inval_ack_o),     128'(e_iack));
            check("model.fill_ack",  128'(bus.fill_ack_o),      128'(e_ack));
            check("model.vld",       128'(bus.wr_cl_vld_o),     128'(e_vld));
            check("model.nc",        128'(bus.wr_cl_nc_o),      128'(e_nc));
            check("model.we",        128'(bus.wr_cl_we_o),      128'(e_we));
            check("model.vld_bits",  128'(bus.wr_vld_bits_o),   128'(e_bits));
            check("model.tag",       128'(bus.wr_cl_tag_o),     128'(e_tag));
            check("model.idx",       128'(bus.wr_cl_idx_o),     128'(e_idx));
            check("model.off",       128'(bus.wr_cl_off_o),     128'(e_off));
            check("model.data",      128'(bus.wr_cl_data_o),    128'(e_data));
            check("model.be",        128'(bus.wr_cl_data_be_o), 128'(e_be));
            if (rst_ni) begin
                if (m_pos >= 0) begin
                    m_pos++;
                    if (m_pos == int'(NumIdx)) begin
                        m_pos     = -1;
                        m_ack_due = m_is_flush;
                    end
                end else if (m_ack_due) begin
                    m_ack_due = 1'b0;
                end else if (!bus.fill_vld_i && !bus.inval_vld_i && bus.flush_i) begin
                    m_pos      = 0;
                    m_is_flush = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    int acks_seen;

    initial begin
        bus.flush_i = 0; bus.inval_vld_i = 0; bus.inval_idx_i = '0; bus.inval_way_i = '0;
        bus.fill_vld_i = 0; bus.fill_nc_i = 0; bus.fill_way_i = '0; bus.fill_tag_i = '0;
        bus.fill_idx_i = '0; bus.fill_off_i = '0; bus.fill_data_i = '0; bus.fill_be_i = '0;

        // Reset state
        tick(); tick();
        @(negedge clk_i);
        check("rst.busy", 128'(bus.busy_o), 128'(1));
        check("rst.vld",  128'(bus.wr_cl_vld_o), 128'(1));
        check("rst.idx",  128'(bus.wr_cl_idx_o), 128'(0));
        check("rst.acks", 128'({bus.flush_ack_o, bus.inval_ack_o, bus.fill_ack_o}), 128'(0));
        tick(); rst_ni = 1;

        // INIT sweep: idx 0..255 on consecutive cycles, then idle
        for (int c = 0; c < 256; c++) begin
            @(negedge clk_i);
            check("init.idx", 128'(bus.wr_cl_idx_o), 128'(c));
        end
        @(negedge clk_i);
        check("init.busy_end", 128'(bus.busy_o), 128'(0));
        check("init.vld_end",  128'(bus.wr_cl_vld_o), 128'(0));

        // Single fill grant
        tick();
        bus.fill_vld_i = 1; bus.fill_way_i = 8'h04; bus.fill_idx_i = 8'h12;
        bus.fill_tag_i = 44'hABC; bus.fill_off_i = 4'h3;
        bus.fill_data_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; bus.fill_be_i = 16'hF00F;
        @(negedge clk_i);
        check("fill.ack",  128'(bus.fill_ack_o), 128'(1));
        check("fill.we",   128'(bus.wr_cl_we_o), 128'(8'h04));
        check("fill.bits", 128'(bus.wr_vld_bits_o), 128'(8'h04));
        check("fill.idx",  128'(bus.wr_cl_idx_o), 128'(8'h12));
        check("fill.tag",  128'(bus.wr_cl_tag_o), 128'(44'hABC));
        tick(); bus.fill_vld_i = 0;

        // Fill and inval together: fill first, inval next cycle
        bus.fill_vld_i = 1; bus.fill_way_i = 8'h01; bus.fill_idx_i = 8'h05; bus.fill_tag_i = 44'h5;
        bus.inval_vld_i = 1; bus.inval_idx_i = 8'h07; bus.inval_way_i = 8'h80;
        @(negedge clk_i);
        check("both.fill_ack",  128'(bus.fill_ack_o), 128'(1));
        check("both.inval_ack", 128'(bus.inval_ack_o), 128'(0));
        tick(); bus.fill_vld_i = 0;
        @(negedge clk_i);
        check("both.inval_ack2", 128'(bus.inval_ack_o), 128'(1));
        check("both.we",   128'(bus.wr_cl_we_o), 128'(8'h80));
        check("both.bits", 128'(bus.wr_vld_bits_o), 128'(0));
        check("both.idx",  128'(bus.wr_cl_idx_o), 128'(8'h07));
        tick(); bus.inval_vld_i = 0;

        // Noncacheable fill
        bus.fill_vld_i = 1; bus.fill_nc_i = 1; bus.fill_way_i = 8'h00; bus.fill_idx_i = 8'hFF;
        @(negedge clk_i);
        check("nc.nc", 128'(bus.wr_cl_nc_o), 128'(1));
        check("nc.we", 128'(bus.wr_cl_we_o), 128'(0));
        tick(); bus.fill_vld_i = 0; bus.fill_nc_i = 0;

        // Flush with an inval raised at sweep cycle 10
        bus.flush_i = 1;
        @(negedge clk_i);
        check("flush.req_nowrite", 128'(bus.wr_cl_vld_o), 128'(0));
        for (int c = 0; c < 256; c++) begin
            tick();
            if (c == 10) begin
                bus.inval_vld_i = 1; bus.inval_idx_i = 8'h33; bus.inval_way_i = 8'h02;
            end
            @(negedge clk_i);
            check("flush.idx", 128'(bus.wr_cl_idx_o), 128'(c));
            check("flush.no_iack", 128'(bus.inval_ack_o), 128'(0));
        end
        tick();
        @(negedge clk_i);
        check("flush.ack",     128'(bus.flush_ack_o), 128'(1));
        check("flush.ack_nowr", 128'(bus.wr_cl_vld_o), 128'(0));
        tick(); bus.flush_i = 0;
        @(negedge clk_i);
        check("flush.idle_busy", 128'(bus.busy_o), 128'(0));
        check("stall.iack", 128'(bus.inval_ack_o), 128'(1));
        check("stall.idx",  128'(bus.wr_cl_idx_o), 128'(8'h33));
        check("stall.we",   128'(bus.wr_cl_we_o), 128'(8'h02));
        tick(); bus.inval_vld_i = 0;

        // Async reset at FLUSH cnt 100
        bus.flush_i = 1;
        for (int c = 0; c <= 100; c++) tick();
        #1 rst_ni = 0;
        #1;
        check("rstmid.idx",  128'(bus.wr_cl_idx_o), 128'(0));
        check("rstmid.busy", 128'(bus.busy_o), 128'(1));
        bus.flush_i = 0;
        tick(); tick(); rst_ni = 1;
        acks_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (c < 256) check("rstmid.sweep_idx", 128'(bus.wr_cl_idx_o), 128'(c));
            if (bus.flush_ack_o) acks_seen++;
        end
        check("rstmid.no_flush_ack", 128'(acks_seen), 128'(0));

        model_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wt_dcache_vld_ctrl.md
Name: wt_dcache_vld_ctrl

Overview:
- Sole driver of the dcache memory's full-cacheline write port (port 0 wr_cl_* signals and wr_vld_bits).
- Arbitrates three sources onto that port: miss-unit refills, single-line invalidations from the memory side, and full-cache flushes.
- Runs a mandatory post-reset sweep that clears every valid bit.
- Issues at most one tag/valid write per cycle.

Parameters:
- NumIdx, 256, number of cache indices (DCACHE_NUM_WORDS).
- NumWays, 8, associativity (DCACHE_SET_ASSOC).
- IdxWidth, $clog2(NumIdx), index width (DCACHE_CL_IDX_WIDTH).
- TagWidth, 44, tag width (DCACHE_TAG_WIDTH).
- LineWidth, 128, cacheline width in bits (DCACHE_LINE_WIDTH).
- OffWidth, 4, line offset width (DCACHE_OFFSET_WIDTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- busy_o  out  1  sweep (INIT or FLUSH) in progress
- flush_i  in  1  flush request, held until ack
- flush_ack_o  out  1  one-cycle pulse, flush complete
- inval_vld_i  in  1  invalidate request, held until ack
- inval_idx_i  in  IdxWidth  index to invalidate
- inval_way_i  in  NumWays  one-hot way to invalidate
- inval_ack_o  out  1  invalidate accepted (write issued this cycle)
- fill_vld_i  in  1  refill write request, held until ack
- fill_ack_o  out  1  refill accepted
- fill_nc_i  in  1  noncacheable refill
- fill_way_i  in  NumWays  one-hot target way (all-zero for nc)
- fill_tag_i  in  TagWidth  refill tag
- fill_idx_i  in  IdxWidth  refill index
- fill_off_i  in  OffWidth  refill offset
- fill_data_i  in  LineWidth  refill data
- fill_be_i  in  LineWidth/8  refill byte enables
- wr_cl_vld_o  out  1  to mem: cacheline write valid
- wr_cl_nc_o  out  1  to mem: noncacheable
- wr_cl_we_o  out  NumWays  to mem: way write enables
- wr_cl_tag_o  out  TagWidth  to mem: tag
- wr_cl_idx_o  out  IdxWidth  to mem: index
- wr_cl_off_o  out  OffWidth  to mem: offset
- wr_cl_data_o  out  LineWidth  to mem: data
- wr_cl_data_be_o  out  LineWidth/8  to mem: byte enables
- wr_vld_bits_o  out  NumWays  to mem: valid bits to write

Behaviour:
- States: INIT, IDLE, FLUSH, DONE. Counter cnt_q, IdxWidth bits.
- Reset: state=INIT, cnt_q=0. The acks, flush_ack_o and the rest of the write outputs are 0 in reset; busy_o=1. During reset wr_cl_vld_o follows the INIT sweep (1, idx=0).
- Sweep cycles (INIT and FLUSH):
  - Outputs: wr_cl_vld_o=1, wr_cl_we_o='1, wr_cl_idx_o=cnt_q, wr_vld_bits_o='0; tag, off, data, be and nc are all '0.
  - cnt_q increments each cycle.
  - At cnt_q==NumIdx-1, cnt_q wraps to 0. INIT goes to IDLE; FLUSH goes to DONE.
  - A sweep takes exactly NumIdx cycles. busy_o=1 throughout.
- All outputs are combinational from state, cnt_q and the granted request. There is no output register, because the memory samples the port directly.
- IDLE priority, one grant per cycle: fill > inval > flush.
  - Fill grant: fill_ack_o=1, wr_cl_vld_o=1. All fill_* fields pass through. wr_cl_we_o=fill_way_i, wr_vld_bits_o=fill_way_i.
  - Inval grant: inval_ack_o=1, wr_cl_vld_o=1, wr_cl_we_o=inval_way_i, wr_cl_idx_o=inval_idx_i, wr_vld_bits_o='0, other fields '0.
  - Flush grant: when flush_i=1 and neither fill nor inval is present, go to FLUSH with cnt_q=0. No write occurs that cycle.
- DONE: flush_ack_o=1 for one cycle, then IDLE. No write in DONE. The requester must drop flush_i in the cycle after the ack. A flush_i still high in IDLE starts a new flush.
- Pending fill/inval during INIT, FLUSH or DONE: no ack; the request stays held and is serviced in IDLE, fill first.
- An inval that is stalled across a flush is still acked and written afterwards. This is harmless: the line is already invalid.
- Idle with no request: wr_cl_vld_o=0 and all write fields '0.
- Async reset mid-sweep or mid-grant: immediate return to INIT. Any outstanding requests remain held by their sources.

Decomposition:
- State enum vld_ctrl_state_e belongs in wt_cache_pkg.
- Width constants come from ariane_pkg/wt_cache_pkg.
- No sub-module: the fixed-priority grant and the counter are inline.

Test Plan:
- Reset release with NumIdx=256: wr_cl_vld_o=1, we=8'hFF, vld_bits=0, idx 0..255 on consecutive cycles, then busy_o=0 at cycle 256; no acks during INIT.
- IDLE, fill_vld_i with way=8'h04, idx=0x12, tag=0xABC: same cycle fill_ack_o=1, wr_cl_we_o=8'h04, wr_vld_bits_o=8'h04, idx=0x12, tag=0xABC passed through.
- Simultaneous fill and inval in IDLE: cycle 0 grants fill only; cycle 1 inval_ack_o=1 with we=inval_way_i and vld_bits=0.
- flush_i in IDLE: one cycle with no write, then 256 sweep cycles, then flush_ack_o pulse, then IDLE; total 258 cycles from request to IDLE.
- inval_vld_i raised at sweep cycle 10: no ack until IDLE; ack in the first IDLE cycle with the correct idx/way.
- rst_ni asserted at FLUSH cnt_q=100: on release the sweep restarts at idx 0 in INIT, and no flush_ack_o is ever emitted.
